// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment encoder/decoder pair: glyph table,
// decoder FSM states and lookup helpers. Segment bit0=a .. bit6=g, 1=lit.
package seg7_pkg;

  typedef enum logic {
    S_TRACK = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } glyph_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index is the hex digit; entry 15 (F) is leftmost.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h7B, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic glyph_t decodeGlyph(input logic [6:0] pat);
    glyph_t res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (GLYPH_TABLE[i] == pat) begin
        res.legal = 1'b1;
        res.digit = 4'(i);
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] encodeGlyph(input logic [3:0] digit);
    return GLYPH_TABLE[digit];
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Measures how long the registered segment pattern has been unchanged and
// flags it as stable once it has been seen for STABLE_CYCLES cycles.
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_i,
  output logic [6:0] stable_pat_o,
  output logic       stable_o,
  output logic       stable_evt_o
);

  localparam logic [3:0] CNT_MAX  = 4'hF;
  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  logic [6:0] prev_q;
  logic [3:0] run_q;
  logic [3:0] run_d;
  logic       same;

  // run_d is the number of cycles the current pattern has been present,
  // including this one; it saturates so a long-held pattern never wraps.
  always_comb begin
    same  = (seg_i == prev_q);
    run_d = 4'd1;
    if (same) begin
      run_d = (run_q == CNT_MAX) ? CNT_MAX : run_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= SEG_BLANK;
      run_q  <= '0;
    end else begin
      prev_q <= seg_i;
      run_q  <= run_d;
    end
  end

  assign stable_pat_o = seg_i;
  assign stable_o     = (run_d >= STABLE_N);
  // Keyed off the previous count so the pulse cannot repeat while saturated.
  assign stable_evt_o = same && (run_q == STABLE_N - 4'd1);

endmodule

// File: rtl/seg7_decoder.sv
// Debounces raw 7-segment lines, decodes stable glyphs to hex digits and
// hands each new result to a ready/valid consumer, counting illegal glyphs.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic [7:0] err_cnt
);

  logic [6:0] seg_q;
  logic [6:0] lastPat_q;
  logic       recheck_q;
  state_e     state_q;

  logic [6:0] stablePat;
  logic       stableLvl;
  logic       stableEvt;
  logic       loadReq;
  glyph_t     glyph;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_i        (seg_q),
    .stable_pat_o (stablePat),
    .stable_o     (stableLvl),
    .stable_evt_o (stableEvt)
  );

  // A fresh stable event is accepted in S_TRACK; on the first cycle back from
  // S_HOLD a pattern that went stable while we were busy is picked up too.
  always_comb begin
    glyph   = decodeGlyph(stablePat);
    loadReq = (state_q == S_TRACK)
              && (stableEvt || (recheck_q && stableLvl))
              && (stablePat != lastPat_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q     <= SEG_BLANK;
      lastPat_q <= SEG_BLANK;
      recheck_q <= 1'b0;
      state_q   <= S_TRACK;
      out_valid <= 1'b0;
      out_digit <= 4'd0;
      out_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      seg_q     <= seg_in;
      recheck_q <= 1'b0;
      case (state_q)
        S_TRACK: begin
          if (loadReq) begin
            lastPat_q <= stablePat;
            // Blank only re-arms lastPat so a repeated digit is emitted again.
            if (stablePat != SEG_BLANK) begin
              state_q   <= S_HOLD;
              out_valid <= 1'b1;
              out_digit <= glyph.digit;
              out_err   <= !glyph.legal;
              if (!glyph.legal && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q   <= S_TRACK;
            out_valid <= 1'b0;
            recheck_q <= 1'b1;
          end
        end
        default: state_q <= S_TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: a history-based reference model is
// compared every cycle, with directed scenarios pinning literal results.
module tb_seg7_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic [7:0] err_cnt;

  int assertCount = 0;
  int failCount = 0;
  bit checkEn = 1'b0;

  logic [6:0] glyphTbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71};

  // Reference model state
  logic [6:0] hist[$];
  bit         mValid, mErr, mHold;
  int         mDigit, mErrCnt;
  logic [6:0] mLast;

  int validSeen, errSeen;
  int digitCnt [16];

  seg7_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rstN, input logic [6:0] seg, input bit ready);
    rst_n     = rstN;
    seg_in    = seg;
    out_ready = ready;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 7'h00, 1'b0);
    tick(1);
    validSeen = 0;
    errSeen   = 0;
    for (int i = 0; i < 16; i++) digitCnt[i] = 0;
    tick(1);
  endtask

  task automatic waitValid(input int maxCycles, output int waited);
    waited = 0;
    while (!out_valid && waited < maxCycles) begin
      tick(1);
      waited++;
    end
    checkOutput("wait_valid", out_valid, 1);
  endtask

  // Model: a pattern is stable once the last STABLE samples of seg_q agree;
  // it is accepted whenever idle and it differs from the last accepted one.
  always @(posedge clk) begin
    int run;
    int idx;
    bit legal;
    logic [6:0] cur;
    if (!rst_n) begin
      mValid = 0; mErr = 0; mHold = 0; mDigit = 0; mErrCnt = 0; mLast = 7'h00;
      hist.delete();
      hist.push_back(7'h00);
    end else begin
      cur = hist[hist.size()-1];
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != cur) break;
        run++;
      end
      if (!mHold) begin
        if (run >= STABLE && cur != mLast) begin
          mLast = cur;
          if (cur != 7'h00) begin
            legal = 0;
            idx = 0;
            for (int g = 0; g < 16; g++) if (glyphTbl[g] == cur) begin legal = 1; idx = g; end
            mValid = 1;
            mDigit = legal ? idx : 0;
            mErr   = !legal;
            if (!legal && mErrCnt < 255) mErrCnt++;
            mHold = 1;
          end
        end
      end else if (out_ready) begin
        mHold = 0;
        mValid = 0;
      end
      hist.push_back(seg_in);
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_out_valid", out_valid, mValid);
      if (mValid) begin
        checkOutput("model_out_digit", out_digit, mDigit);
        checkOutput("model_out_err", out_err, mErr);
      end
      checkOutput("model_err_cnt", err_cnt, mErrCnt);
      if (out_valid) validSeen++;
      if (out_valid && out_err) errSeen++;
      if (out_valid && !out_err) digitCnt[out_digit]++;
    end
  end

  initial begin
    int waited;
    logic [6:0] pat;
    int hold;
    applyStimulus(1'b0, 7'h00, 1'b0);
    @(posedge clk);
    #1 checkEn = 1'b1;

    // Reset state
    resetDut();
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_digit", out_digit, 0);
    checkOutput("reset_err", out_err, 0);
    checkOutput("reset_err_cnt", err_cnt, 0);

    // 5B from cycle 0: single-cycle valid at cycle 5 with digit 2
    resetDut();
    applyStimulus(1'b1, 7'h5B, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checkOutput($sformatf("s1_valid_c%0d", k), out_valid, (k == 5) ? 1 : 0);
      if (k == 5) begin
        checkOutput("s1_digit", out_digit, 2);
        checkOutput("s1_err", out_err, 0);
      end
    end

    // Short glitch of 06 followed by blank produces nothing
    resetDut();
    applyStimulus(1'b1, 7'h06, 1'b1);
    tick(2);
    applyStimulus(1'b1, 7'h00, 1'b1);
    tick(10);
    checkOutput("s2_no_valid", validSeen, 0);
    checkOutput("s2_err_cnt", err_cnt, 0);

    // 8, blank, 8 gives two results
    resetDut();
    applyStimulus(1'b1, 7'h7F, 1'b1); tick(8);
    applyStimulus(1'b1, 7'h00, 1'b1); tick(8);
    applyStimulus(1'b1, 7'h7F, 1'b1); tick(8);
    checkOutput("s3_results", validSeen, 2);
    checkOutput("s3_eights", digitCnt[8], 2);

    // Illegal glyph and err_cnt saturation
    resetDut();
    applyStimulus(1'b1, 7'h49, 1'b1); tick(8);
    checkOutput("s4_err_pulse", errSeen, 1);
    checkOutput("s4_err_cnt1", err_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 7'h00, 1'b1); tick(6);
      applyStimulus(1'b1, 7'h49, 1'b1); tick(6);
    end
    checkOutput("s4_err_pulses", errSeen, 301);
    checkOutput("s4_err_cnt_sat", err_cnt, 255);

    // Back-pressure: intermediate stable patterns are dropped
    resetDut();
    applyStimulus(1'b1, 7'h3F, 1'b0); tick(8);
    checkOutput("s5_valid0", out_valid, 1);
    checkOutput("s5_digit0", out_digit, 0);
    applyStimulus(1'b1, 7'h66, 1'b0); tick(8);
    applyStimulus(1'b1, 7'h6D, 1'b0); tick(8);
    checkOutput("s5_hold_valid", out_valid, 1);
    checkOutput("s5_hold_digit", out_digit, 0);
    applyStimulus(1'b1, 7'h6D, 1'b1); tick(1);
    checkOutput("s5_drop_valid", out_valid, 0);
    tick(1);
    checkOutput("s5_next_valid", out_valid, 1);
    checkOutput("s5_next_digit", out_digit, 5);
    tick(3);
    checkOutput("s5_no_four", digitCnt[4], 0);

    // Reset during hold discards the result; same glyph is emitted again
    resetDut();
    applyStimulus(1'b1, 7'h6F, 1'b0); tick(8);
    checkOutput("s6_valid", out_valid, 1);
    checkOutput("s6_digit", out_digit, 9);
    applyStimulus(1'b0, 7'h6F, 1'b0); tick(1);
    checkOutput("s6_reset_valid", out_valid, 0);
    applyStimulus(1'b1, 7'h6F, 1'b0);
    waitValid(10, waited);
    checkOutput("s6_latency", waited, STABLE + 1);
    checkOutput("s6_redigit", out_digit, 9);

    // Random patterns, hold times, back-pressure and occasional resets
    resetDut();
    for (int e = 0; e < 400; e++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: pat = glyphTbl[$urandom_range(0, 15)];
        6, 7:             pat = 7'h00;
        default:          pat = 7'($urandom);
      endcase
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        applyStimulus(($urandom_range(0, 99) != 0), pat, ($urandom_range(0, 3) != 0));
        tick(1);
      end
    end
    applyStimulus(1'b1, 7'h00, 1'b1);
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted (legal range 2..15).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port seg_in  input  7  raw segment lines, bit0=a .. bit6=g, 1=lit, same mapping as the team's hex-to-7seg encoder.
REQ-005 SHALL have port out_valid  output  1  decoded result available.
REQ-006 SHALL have port out_ready  input  1  consumer accepts result.
REQ-007 SHALL have port out_digit  output  4  decoded hex value 0..F.
REQ-008 SHALL have port out_err  output  1  accepted pattern is not one of the 16 legal glyphs.
REQ-009 SHALL have port err_cnt  output  8  count of accepted illegal patterns.

Function
REQ-010 SHALL register seg_in once (seg_q) before any comparison; seg_in is never used combinationally.
REQ-011 SHALL count consecutive cycles seg_q is unchanged; any change restarts the count; the count saturates (no wrap).
REQ-012 SHALL deem a pattern stable when it has been present on seg_q for STABLE_CYCLES consecutive cycles.
REQ-013 SHALL emit a result only when a stable pattern differs from last_pat (last accepted pattern); last_pat is then updated to it.
REQ-014 SHALL treat the blank pattern 7'b0000000 as "no digit": update last_pat, emit nothing, no error, so a repeated digit separated by blank is emitted again.
REQ-015 SHALL decode the 16 legal glyphs exactly: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,B=7C,C=39,D=5E,E=7B,F=71 (hex of seg bits 6..0).
REQ-016 SHALL, for any other non-blank pattern, emit with out_err=1, out_digit=0, and increment err_cnt saturating at 255.
REQ-017 SHALL use FSM states S_TRACK and S_HOLD; S_TRACK -> S_HOLD when a result is loaded; S_HOLD -> S_TRACK on out_valid && out_ready.
REQ-018 SHALL hold out_valid, out_digit, out_err constant in S_HOLD until handshake; out_valid drops the cycle after handshake.
REQ-019 SHALL keep stability tracking running in S_HOLD; patterns that become stable and then change during S_HOLD are dropped; the pattern stable at return to S_TRACK is emitted if it differs from last_pat.
REQ-020 SHALL assert out_valid exactly STABLE_CYCLES+1 cycles after seg_in first presents a new pattern held constant, when in S_TRACK with no pending result.
REQ-021 SHALL count illegal patterns in err_cnt at acceptance time, independent of out_ready.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge: out_valid=0, out_digit=0, out_err=0, err_cnt=0, seg_q=0, stability count=0, last_pat=blank, state=S_TRACK.
REQ-023 SHALL, on reset during S_HOLD, discard the pending result with no handshake.
REQ-024 SHALL ignore out_ready and seg_in while rst_n=0.

Structure
REQ-025 SHALL take the 16-entry glyph table and the FSM state enum from shared package seg7_pkg, also used by the encoder.
REQ-026 SHALL place stability counting in one sub-module seg7_stable_filter (inputs seg_q, outputs stable pattern plus 1-cycle stable-event pulse).

Verification
REQ-027 SHALL cover: STABLE_CYCLES=4, seg_in=7'h5B from cycle 0, out_ready=1 -> out_valid=1 at cycle 5, out_digit=2, out_err=0, single cycle.
REQ-028 SHALL cover: seg_in=7'h06 for 2 cycles then 7'h00 -> no out_valid, err_cnt=0.
REQ-029 SHALL cover: 7'h7F stable, blank stable, 7'h7F stable -> two results, both out_digit=8.
REQ-030 SHALL cover: seg_in=7'h49 stable -> out_valid with out_err=1, out_digit=0, err_cnt=1; 300 such alternating-with-blank events -> err_cnt=255.
REQ-031 SHALL cover: out_ready=0, 7'h3F accepted, then 7'h66 then 7'h6D each stable -> out_digit holds 0; after out_ready=1 next result is 5, 4 never emitted.
REQ-032 SHALL cover: rst_n=0 for one cycle while out_valid=1 -> out_valid=0 next cycle; same glyph re-presented stable -> emitted again.
